ft_cmd_rx: RTL and testbench

FT_CMD_RX -- requirements
Module: ft_cmd_rx

---
 rtl/ft_cmd_rx.sv | 174 +++++++++++++++++
 tb/tb_ft_cmd_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_cmd_rx.sv
// ft_cmd_rx -- FT2232 receive-side command framer.
//
// Reads bytes from the FT2232 receive FIFO through the shared data bus and
// assembles 6-byte frames (0xA5, addr, data[31:24] .. data[7:0]) into a
// single command presented on a valid/ready handshake.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   nrxf_i       FIFO-not-empty from FT2232 (active low, asynchronous)
//   d_i          FT2232 data bus (input half)
//   nrd_o        FT2232 read strobe (active low)
//   bus_req_o    request ownership of the shared data bus
//   bus_gnt_i    shared bus granted to this block
//   cmd_valid_o  command present on addr_o/data_o
//   cmd_ready_i  consumer accepts the command
//   addr_o       command register address
//   data_o       command payload
//   err_cnt_o    saturating count of framing errors and inter-byte timeouts
//
// state   | meaning
// IDLE    | waiting for FIFO data and an empty command slot
// REQ     | bus requested, waiting for grant
// RD_LOW  | nrd_o low, byte sampled on the last cycle
// RD_HIGH | nrd_o high recovery time before the next read

module ft_cmd_rx #(
  parameter int RD_LOW_CYCLES  = 4,
  parameter int RD_HIGH_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        nrxf_i,
  input  logic [7:0]  d_i,
  output logic        nrd_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [7:0]  addr_o,
  output logic [31:0] data_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, RD_LOW, RD_HIGH} state_t;

  localparam logic [3:0]  LOW_LOAD  = 4'(RD_LOW_CYCLES - 1);
  localparam logic [3:0]  HIGH_LOAD = 4'(RD_HIGH_CYCLES - 1);
  localparam logic [15:0] GAP_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  state_t      state, state_nxt;
  logic [3:0]  phase_cnt, phase_cnt_nxt;
  logic        sample;
  logic        rxf_meta, rxf_s;
  logic        nrd_q, bus_req_q;
  logic [2:0]  byte_idx;
  logic [15:0] gap_cnt;
  logic        cmd_valid_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic [7:0]  err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
    end else begin
      rxf_meta <= nrxf_i;
      rxf_s    <= rxf_meta;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
      nrd_q     <= 1'b1;
      bus_req_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_cnt_nxt;
      // Strobes are registered from the next state so nrd_o never glitches
      // while the state encoding changes several bits at once.
      nrd_q     <= (state_nxt != RD_LOW);
      bus_req_q <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    sample        = 1'b0;
    case (state)
      IDLE: begin
        if (!rxf_s && !cmd_valid_q) state_nxt = REQ;
      end
      REQ: begin
        if (bus_gnt_i) begin
          state_nxt     = RD_LOW;
          phase_cnt_nxt = LOW_LOAD;
        end
      end
      RD_LOW: begin
        if (phase_cnt == 4'd0) begin
          sample        = 1'b1;
          state_nxt     = RD_HIGH;
          phase_cnt_nxt = HIGH_LOAD;
        end else begin
          phase_cnt_nxt = phase_cnt - 4'd1;
        end
      end
      RD_HIGH: begin
        if (phase_cnt == 4'd0) state_nxt = IDLE;
        else                   phase_cnt_nxt = phase_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      byte_idx    <= 3'd0;
      gap_cnt     <= 16'd0;
      cmd_valid_q <= 1'b0;
      addr_q      <= 8'd0;
      data_q      <= 32'd0;
      err_q       <= 8'd0;
    end else begin
      if (cmd_valid_q && cmd_ready_i) cmd_valid_q <= 1'b0;

      // A sample takes priority over a coincident timeout.
      if (sample) begin
        gap_cnt <= 16'd0;
        case (byte_idx)
          3'd0: begin
            if (d_i == SYNC_BYTE)   byte_idx <= 3'd1;
            else if (err_q != 8'hFF) err_q   <= err_q + 8'd1;
          end
          3'd1: begin
            addr_q   <= d_i;
            byte_idx <= 3'd2;
          end
          default: begin
            data_q <= {data_q[23:0], d_i};
            if (byte_idx == 3'd5) begin
              cmd_valid_q <= 1'b1;
              byte_idx    <= 3'd0;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        endcase
      end else if (byte_idx != 3'd0 && !cmd_valid_q) begin
        if (gap_cnt == GAP_LIMIT) begin
          byte_idx <= 3'd0;
          gap_cnt  <= 16'd0;
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end
    end
  end

  assign nrd_o       = nrd_q;
  assign bus_req_o   = bus_req_q;
  assign cmd_valid_o = cmd_valid_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_ft_cmd_rx.sv
module tb_ft_cmd_rx;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        nrxf_i;
  logic [7:0]  d_i;
  logic        nrd_o;
  logic        bus_req_o;
  logic        bus_gnt_i = 1'b1;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b1;
  logic [7:0]  addr_o;
  logic [31:0] data_o;
  logic [7:0]  err_cnt_o;

  ft_cmd_rx dut (
    .clk_i(clk_i), .reset_i(reset_i), .nrxf_i(nrxf_i), .d_i(d_i),
    .nrd_o(nrd_o), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .addr_o(addr_o), .data_o(data_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // FT2232 receive FIFO model: a byte pops when nrd rises outside reset
  logic [7:0] fifo_mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  logic hold = 1'b0;
  assign nrxf_i = hold || (wr_ptr == rd_ptr);
  assign d_i    = fifo_mem[rd_ptr[11:0]];
  always @(posedge nrd_o) if (reset_i === 1'b0) rd_ptr <= rd_ptr + 1;

  int total = 0;
  int bad   = 0;
  int n_cmds = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frames are whole 6-byte lists starting with A5
  logic [7:0]  m_frm [$];
  logic [39:0] exp_q [$];
  int m_err = 0;

  task automatic model_byte(input logic [7:0] b);
    if (m_frm.size() == 0 && b != 8'hA5) begin
      if (m_err < 255) m_err++;
    end else begin
      m_frm.push_back(b);
      if (m_frm.size() == 6) begin
        exp_q.push_back({m_frm[1], m_frm[2], m_frm[3], m_frm[4], m_frm[5]});
        m_frm.delete();
      end
    end
  endtask

  task automatic model_timeout();
    if (m_frm.size() != 0) begin
      m_frm.delete();
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic model_reset();
    m_frm.delete();
    exp_q.delete();
    m_err = 0;
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo_mem[wr_ptr[11:0]] = b;
    wr_ptr++;
  endtask

  task automatic send(input logic [7:0] b);
    push_raw(b);
    model_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
    send(8'hA5); send(a);
    send(d[31:24]); send(d[23:16]); send(d[15:8]); send(d[7:0]);
  endtask

  bit rnd = 1'b0;

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rnd) begin
      cmd_ready_i = ($urandom_range(0, 3) != 0);
      bus_gnt_i   = ($urandom_range(0, 3) != 0);
      hold        = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < budget) begin
      step();
      n++;
      if (rd_ptr == wr_ptr && !bus_req_o && !cmd_valid_o) quiet++;
      else quiet = 0;
    end
    chk("idle_reached", 64'(quiet >= 8), 64'd1);
    chk("err_cnt", err_cnt_o, 64'(m_err));
    chk("pending_cmds", 64'(exp_q.size()), 64'd0);
  endtask

  // Protocol / scoreboard monitor
  int          low_len = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_cmd;
  logic [39:0] mon_exp;

  always @(negedge clk_i) begin
    if (reset_i !== 1'b0) begin
      low_len    = 0;
      prev_stall = 1'b0;
    end else begin
      if (nrd_o === 1'b0) begin
        low_len++;
        if (low_len == 1) chk("bus_req_during_read", bus_req_o, 64'd1);
      end else if (low_len != 0) begin
        chk("nrd_low_cycles", 64'(low_len), 64'd4);
        low_len = 0;
      end
      if (cmd_valid_o) begin
        chk("nrd_high_while_valid", nrd_o, 64'd1);
        if (prev_stall) chk("cmd_stable", {addr_o, data_o}, prev_cmd);
      end
      if (cmd_valid_o && cmd_ready_i) begin
        mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 40'bx;
        chk("cmd", {addr_o, data_o}, mon_exp);
        n_cmds++;
      end
      prev_stall = cmd_valid_o && !cmd_ready_i;
      prev_cmd   = {addr_o, data_o};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    int base;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_nrd", nrd_o, 64'd1);
    chk("rst_bus_req", bus_req_o, 64'd0);
    chk("rst_valid", cmd_valid_o, 64'd0);
    chk("rst_addr", addr_o, 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_err", err_cnt_o, 64'd0);
    reset_i = 1'b0;

    // basic frame
    send_frame(8'h12, 32'hDEADBEEF);
    wait_idle(500);
    chk("f1_addr", addr_o, 64'h12);
    chk("f1_data", data_o, 64'hDEADBEEF);
    chk("f1_count", 64'(n_cmds), 64'd1);

    // leading garbage byte
    send(8'h00);
    send_frame(8'h01, 32'h00000007);
    wait_idle(500);
    chk("f2_err", err_cnt_o, 64'd1);
    chk("f2_addr", addr_o, 64'h01);
    chk("f2_data", data_o, 64'h7);

    // backpressure
    cmd_ready_i = 1'b0;
    send_frame(8'h44, 32'h01020304);
    send_frame(8'h55, 32'h0A0B0C0D);
    n = 0;
    while (!cmd_valid_o && n < 500) begin step(); n++; end
    chk("bp_valid_rise", cmd_valid_o, 64'd1);
    snap = rd_ptr;
    repeat (60) step();
    chk("bp_no_read", 64'(rd_ptr), 64'(snap));
    chk("bp_nrd_high", nrd_o, 64'd1);
    chk("bp_valid_held", cmd_valid_o, 64'd1);
    chk("bp_addr", addr_o, 64'h44);
    chk("bp_data", data_o, 64'h01020304);
    chk("bp_fifo_pending", nrxf_i, 64'd0);
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    chk("bp_valid_drop", cmd_valid_o, 64'd0);
    n = 0;
    while (rd_ptr == snap && n < 100) begin step(); n++; end
    chk("bp_reads_resume", 64'(rd_ptr != snap), 64'd1);
    cmd_ready_i = 1'b1;
    wait_idle(500);

    // inter-byte timeout
    send(8'hA5); send(8'h33);
    wait_idle(300);
    repeat (65000) step();
    chk("no_early_timeout", err_cnt_o, 64'(m_err));
    repeat (1000) step();
    model_timeout();
    chk("timeout_err", err_cnt_o, 64'(m_err));
    snap = n_cmds;
    send_frame(8'h77, 32'hCAFEF00D);
    wait_idle(500);
    chk("timeout_next_frame", 64'(n_cmds - snap), 64'd1);
    chk("timeout_addr", addr_o, 64'h77);

    // grant withheld
    bus_gnt_i = 1'b0;
    send_frame(8'h88, 32'h11223344);
    snap = rd_ptr;
    repeat (100) step();
    chk("nogrant_req", bus_req_o, 64'd1);
    chk("nogrant_nrd", nrd_o, 64'd1);
    chk("nogrant_no_pop", 64'(rd_ptr), 64'(snap));
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("grant_nrd_before_edge", nrd_o, 64'd1);
    @(negedge clk_i);
    chk("grant_nrd_after_edge", nrd_o, 64'd0);
    wait_idle(500);

    // reset during the fourth byte
    base = rd_ptr;
    push_raw(8'hA5); push_raw(8'h11); push_raw(8'h22);
    push_raw(8'h33); push_raw(8'h44); push_raw(8'h55);
    n = 0;
    while (!(rd_ptr == base + 3 && nrd_o == 1'b0) && n < 300) begin step(); n++; end
    chk("reached_byte3", 64'(rd_ptr - base), 64'd3);
    reset_i = 1'b1;
    #1;
    chk("arst_nrd", nrd_o, 64'd1);
    chk("arst_bus_req", bus_req_o, 64'd0);
    chk("arst_valid", cmd_valid_o, 64'd0);
    chk("arst_addr", addr_o, 64'd0);
    chk("arst_data", data_o, 64'd0);
    chk("arst_err", err_cnt_o, 64'd0);
    repeat (2) step();
    reset_i = 1'b0;
    model_reset();
    model_byte(8'h33); model_byte(8'h44); model_byte(8'h55);
    send_frame(8'h66, 32'h0BADCAFE);
    wait_idle(800);
    chk("arst_next_addr", addr_o, 64'h66);
    chk("arst_next_data", data_o, 64'h0BADCAFE);

    // randomized traffic with random ready/grant/FIFO stalls
    rnd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
      send_frame(8'($urandom_range(0, 255)), $urandom);
    end
    wait_idle(20000);
    rnd = 1'b0;
    cmd_ready_i = 1'b1;
    bus_gnt_i   = 1'b1;
    hold        = 1'b0;
    wait_idle(200);

    // error counter saturation
    for (int i = 0; i < 260; i++) send(8'h00);
    wait_idle(10000);
    chk("err_saturated", err_cnt_o, 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
